// File: rtl/seven_seg_reader.sv
// Monitors a multiplexed 7-segment bus and recovers the hex value on each digit.
// Debounced digits are assembled into frames and handed off over valid/ready.
module seven_seg_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:6]            display,
    input  logic [DIGITS-1:0]     digit_sel,
    output logic [4*DIGITS-1:0]   frame_value,
    output logic [DIGITS-1:0]     frame_bad,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  overrun
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CPRE = CW'(STABLE_CYCLES - 1);

    logic [DIGITS-1:0]   r_sel;
    logic [0:6]          r_seg;
    logic [CW-1:0]       r_cnt;
    logic [4*DIGITS-1:0] r_work_val;
    logic [DIGITS-1:0]   r_work_bad;
    logic [DIGITS-1:0]   r_mask;

    logic       w_onehot;
    logic       w_stable;
    logic       w_capture;
    logic       w_full;
    logic       w_free;
    logic       w_complete;
    logic [4:0] w_dec;

    // Returns {bad, nibble}; anything outside the 16 glyphs is bad with nibble 0.
    function automatic logic [4:0] f_decode(input logic [0:6] seg);
        logic [4:0] r;
        case (seg)
            7'b1111110: r = 5'h00;
            7'b0110000: r = 5'h01;
            7'b1101101: r = 5'h02;
            7'b1111001: r = 5'h03;
            7'b0110011: r = 5'h04;
            7'b1011011: r = 5'h05;
            7'b1011111: r = 5'h06;
            7'b1110000: r = 5'h07;
            7'b1111111: r = 5'h08;
            7'b1111011: r = 5'h09;
            7'b1110111: r = 5'h0A;
            7'b0011111: r = 5'h0B;
            7'b1001110: r = 5'h0C;
            7'b0111101: r = 5'h0D;
            7'b1001111: r = 5'h0E;
            7'b1000111: r = 5'h0F;
            default:    r = 5'h10;
        endcase
        return r;
    endfunction

    assign w_onehot   = ($countones(digit_sel) == 1);
    assign w_stable   = w_onehot && (digit_sel == r_sel) && (display == r_seg);
    assign w_capture  = w_stable && (r_cnt == CPRE);
    assign w_dec      = f_decode(display);
    assign w_full     = &r_mask;
    assign w_free     = !frame_valid || frame_ready;
    assign w_complete = w_full && w_free;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel       <= '0;
            r_seg       <= '0;
            r_cnt       <= '0;
            r_work_val  <= '0;
            r_work_bad  <= '0;
            r_mask      <= '0;
            frame_value <= '0;
            frame_bad   <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            r_sel <= digit_sel;
            r_seg <= display;

            if (!w_stable)
                r_cnt <= '0;
            else if (r_cnt != CMAX)
                r_cnt <= r_cnt + 1'b1;

            for (int i = 0; i < DIGITS; i++) begin
                if (w_capture && digit_sel[i]) begin
                    r_work_val[4*i +: 4] <= w_dec[3:0];
                    r_work_bad[i]        <= w_dec[4];
                end
            end

            // A capture landing on the completion edge starts the next frame.
            r_mask <= (w_complete ? '0 : r_mask)
                    | (w_capture ? digit_sel : '0);

            if (w_complete) begin
                frame_value <= r_work_val;
                frame_bad   <= r_work_bad;
                frame_valid <= 1'b1;
            end else if (frame_ready) begin
                frame_valid <= 1'b0;
            end

            if (w_full && !w_free)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed testbench for seven_seg_reader (DIGITS=4, STABLE_CYCLES=4).
// Each scenario task drives stimulus and checks outputs inline.
module tb_seven_seg_reader;

    localparam logic [6:0] S0 = 7'b1111110;
    localparam logic [6:0] S1 = 7'b0110000;
    localparam logic [6:0] S2 = 7'b1101101;
    localparam logic [6:0] S3 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0110011;
    localparam logic [6:0] S5 = 7'b1011011;
    localparam logic [6:0] S6 = 7'b1011111;
    localparam logic [6:0] S7 = 7'b1110000;
    localparam logic [6:0] S8 = 7'b1111111;
    localparam logic [6:0] S9 = 7'b1111011;
    localparam logic [6:0] SA = 7'b1110111;
    localparam logic [6:0] SB = 7'b0011111;
    localparam logic [6:0] SC = 7'b1001110;
    localparam logic [6:0] SD = 7'b0111101;
    localparam logic [6:0] SE = 7'b1001111;
    localparam logic [6:0] SF = 7'b1000111;
    localparam logic [6:0] SBLANK = 7'b0000000;

    logic        clk;
    logic        reset;
    logic [0:6]  display;
    logic [3:0]  digit_sel;
    logic [15:0] frame_value;
    logic [3:0]  frame_bad;
    logic        frame_valid;
    logic        frame_ready;
    logic        overrun;

    int tests;
    int fails;

    seven_seg_reader #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .display     (display),
        .digit_sel   (digit_sel),
        .frame_value (frame_value),
        .frame_bad   (frame_bad),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic hold(input logic [3:0] sel, input logic [6:0] seg,
                        input int n);
        digit_sel = sel;
        display   = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cap(input int dig, input logic [6:0] seg);
        hold(4'(1 << dig), seg, 5);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept();
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if (frame_value !== 16'h0) begin
            $display("FAIL reset_value got %h want 0000", frame_value); fails++;
        end
        tests++;
        if (frame_bad !== 4'h0) begin
            $display("FAIL reset_bad got %b want 0000", frame_bad); fails++;
        end
        tests++;
        if (frame_valid !== 1'b0) begin
            $display("FAIL reset_valid got %b want 0", frame_valid); fails++;
        end
        tests++;
        if (overrun !== 1'b0) begin
            $display("FAIL reset_overrun got %b want 0", overrun); fails++;
        end
    endtask

    task automatic test_frame();
        cap(0, SA); cap(1, SB); cap(2, SC); cap(3, SD);
        tests++;
        if (frame_valid !== 1'b0) begin
            $display("FAIL frame_latency got %b want 0", frame_valid); fails++;
        end
        step();
        tests++;
        if (frame_valid !== 1'b1) begin
            $display("FAIL frame_valid got %b want 1", frame_valid); fails++;
        end
        tests++;
        if (frame_value !== 16'hDCBA) begin
            $display("FAIL frame_value got %h want dcba", frame_value); fails++;
        end
        tests++;
        if (frame_bad !== 4'b0000) begin
            $display("FAIL frame_bad got %b want 0000", frame_bad); fails++;
        end
        accept();
        tests++;
        if (frame_valid !== 1'b0) begin
            $display("FAIL frame_accept got %b want 0", frame_valid); fails++;
        end
    endtask

    task automatic test_short_hold();
        hold(4'b0001, S8, 4);
        hold(4'b0000, SBLANK, 2);
        cap(1, S1); cap(2, S2); cap(3, S3);
        hold(4'b0000, SBLANK, 2);
        tests++;
        if (frame_valid !== 1'b0) begin
            $display("FAIL short_nocap got %b want 0", frame_valid); fails++;
        end
        cap(0, S8);
        step();
        tests++;
        if (frame_valid !== 1'b1 || frame_value !== 16'h3218) begin
            $display("FAIL short_frame got %b/%h want 1/3218",
                     frame_valid, frame_value); fails++;
        end
        accept();
    endtask

    task automatic test_blank();
        cap(0, S1); cap(1, S2); cap(2, SBLANK); cap(3, S3);
        step();
        tests++;
        if (frame_valid !== 1'b1 || frame_value !== 16'h3021) begin
            $display("FAIL blank_value got %b/%h want 1/3021",
                     frame_valid, frame_value); fails++;
        end
        tests++;
        if (frame_bad !== 4'b0100) begin
            $display("FAIL blank_bad got %b want 0100", frame_bad); fails++;
        end
        accept();
    endtask

    task automatic test_multihot();
        hold(4'b0110, S5, 10);
        cap(0, S1); cap(3, SF);
        hold(4'b0000, SBLANK, 2);
        tests++;
        if (frame_valid !== 1'b0) begin
            $display("FAIL multihot_nocap got %b want 0", frame_valid); fails++;
        end
        cap(1, S7); cap(2, S9);
        step();
        tests++;
        if (frame_valid !== 1'b1 || frame_value !== 16'hF971) begin
            $display("FAIL multihot_frame got %b/%h want 1/f971",
                     frame_valid, frame_value); fails++;
        end
        tests++;
        if (frame_bad !== 4'b0000) begin
            $display("FAIL multihot_bad got %b want 0000", frame_bad); fails++;
        end
        accept();
    endtask

    task automatic test_overrun();
        cap(0, S1); cap(1, S2); cap(2, S3); cap(3, S4);
        step();
        tests++;
        if (frame_valid !== 1'b1 || frame_value !== 16'h4321) begin
            $display("FAIL ovr_frame_a got %b/%h want 1/4321",
                     frame_valid, frame_value); fails++;
        end
        tests++;
        if (overrun !== 1'b0) begin
            $display("FAIL ovr_early got %b want 0", overrun); fails++;
        end
        cap(0, S5); cap(1, S6); cap(2, S7); cap(3, S8);
        step();
        tests++;
        if (overrun !== 1'b1) begin
            $display("FAIL ovr_set got %b want 1", overrun); fails++;
        end
        tests++;
        if (frame_valid !== 1'b1 || frame_value !== 16'h4321) begin
            $display("FAIL ovr_hold_a got %b/%h want 1/4321",
                     frame_valid, frame_value); fails++;
        end
        accept();
        tests++;
        if (frame_valid !== 1'b1 || frame_value !== 16'h8765) begin
            $display("FAIL ovr_frame_b got %b/%h want 1/8765",
                     frame_valid, frame_value); fails++;
        end
        accept();
        tests++;
        if (frame_valid !== 1'b0 || overrun !== 1'b1) begin
            $display("FAIL ovr_drain got %b/%b want 0/1",
                     frame_valid, overrun); fails++;
        end
    endtask

    task automatic test_reset_mid();
        cap(0, S9); cap(1, S9);
        #2 reset = 1'b1;
        #1;
        tests++;
        if (frame_value !== 16'h0 || frame_bad !== 4'h0 ||
            frame_valid !== 1'b0 || overrun !== 1'b0) begin
            $display("FAIL midreset got %h/%b/%b/%b want 0000/0000/0/0",
                     frame_value, frame_bad, frame_valid, overrun); fails++;
        end
        #2 reset = 1'b0;
        step();
        cap(2, S6); cap(3, S5);
        hold(4'b0000, SBLANK, 2);
        tests++;
        if (frame_valid !== 1'b0) begin
            $display("FAIL midreset_partial got %b want 0", frame_valid); fails++;
        end
        cap(0, SE); cap(1, S0);
        step();
        tests++;
        if (frame_valid !== 1'b1 || frame_value !== 16'h560E) begin
            $display("FAIL midreset_frame got %b/%h want 1/560e",
                     frame_valid, frame_value); fails++;
        end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset       = 1'b1;
        display     = 7'b0;
        digit_sel   = 4'b0;
        frame_ready = 1'b0;
        #12 reset = 1'b0;
        step();
        test_reset();
        test_frame();
        test_short_hold();
        test_blank();
        test_multihot();
        test_overrun();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
